// File: rtl/hcg_lpi_multi_ctrl_if.sv
// Per-channel AXI low-power-interface bundle between the HCG controller and its peripherals.
// The master side is the controller; the slave side is the peripheral/subsystem view.
interface hcg_lpi_multi_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] cactive_i;
    logic [NUM_CH-1:0] csysack_i;
    logic [NUM_CH-1:0] domain_ready_i;
    logic [NUM_CH-1:0] force_on_i;
    logic [NUM_CH-1:0] csysreq_o;
    logic [NUM_CH-1:0] ch_clk_en_o;
    logic [NUM_CH-1:0] deny_o;

    modport master (
        input  cactive_i,
        input  csysack_i,
        input  domain_ready_i,
        input  force_on_i,
        output csysreq_o,
        output ch_clk_en_o,
        output deny_o
    );

    modport slave (
        output cactive_i,
        output csysack_i,
        output domain_ready_i,
        output force_on_i,
        input  csysreq_o,
        input  ch_clk_en_o,
        input  deny_o
    );
endinterface

// File: rtl/hcg_lpi_multi_ctrl.sv
// Multi-channel LPI handshake controller with idle hysteresis, denial handling and force-on,
// producing per-channel clock enables and a combined enable for the shared clock gate.
module hcg_lpi_multi_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int SYNC_DEPTH = 2,
    parameter int IDLE_CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
    output logic                  hcg_clk_en_o,
    hcg_lpi_multi_ctrl_if.master  lpi
);
    // Only depths of 2 or 3 are meaningful; anything else falls back to 2.
    localparam int SD = (SYNC_DEPTH == 3) ? 3 : 2;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_WAKE    = 2'd1,
        ST_RUN     = 2'd2,
        ST_REQ     = 2'd3
    } state_t;

    logic [SD-1:0][NUM_CH-1:0] cact_sync_reg;
    logic [SD-1:0][NUM_CH-1:0] ack_sync_reg;
    logic [SD-1:0][NUM_CH-1:0] rdy_sync_reg;
    logic [NUM_CH-1:0]         cactive_s;
    logic [NUM_CH-1:0]         csysack_s;
    logic [NUM_CH-1:0]         ready_s;

    logic [NUM_CH-1:0]         csysreq_next;
    logic [NUM_CH-1:0]         ch_en_next;
    logic [NUM_CH-1:0]         deny_next;
    logic [NUM_CH-1:0]         csysreq_reg;
    logic [NUM_CH-1:0]         ch_en_reg;
    logic [NUM_CH-1:0]         deny_reg;
    logic                      hcg_en_reg;
    logic [IDLE_CNT_W-1:0]     eff_thresh_m1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cact_sync_reg <= '0;
            ack_sync_reg  <= '0;
            rdy_sync_reg  <= '0;
        end else begin
            cact_sync_reg <= {cact_sync_reg[SD-2:0], lpi.cactive_i};
            ack_sync_reg  <= {ack_sync_reg[SD-2:0], lpi.csysack_i};
            rdy_sync_reg  <= {rdy_sync_reg[SD-2:0], lpi.domain_ready_i};
        end
    end

    assign cactive_s = cact_sync_reg[SD-1];
    assign csysack_s = ack_sync_reg[SD-1];
    assign ready_s   = rdy_sync_reg[SD-1];

    // A threshold of 0 behaves as 1, so the compare value is max(thresh,1)-1.
    assign eff_thresh_m1 = (idle_thresh_i == '0) ? '0 : idle_thresh_i - IDLE_CNT_W'(1);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t                state_reg;
        state_t                state_next;
        logic [IDLE_CNT_W-1:0] idle_cnt_reg;
        logic [IDLE_CNT_W-1:0] idle_cnt_next;
        logic                  wake;
        logic                  idle;
        logic                  deny_l;
        logic                  req_l;
        logic                  en_l;

        assign wake = (cactive_s[gi] & ready_s[gi]) | lpi.force_on_i[gi];
        assign idle = ~cactive_s[gi] & ~ready_s[gi] & ~lpi.force_on_i[gi];

        always_comb begin
            state_next = state_reg;
            deny_l     = 1'b0;
            case (state_reg)
                ST_STOPPED: if (wake) state_next = ST_WAKE;
                ST_WAKE:    if (csysack_s[gi]) state_next = ST_RUN;
                ST_RUN:     if (idle && (idle_cnt_reg >= eff_thresh_m1)) state_next = ST_REQ;
                ST_REQ: begin
                    if (!csysack_s[gi]) begin
                        // Peripheral dropped ACK while still (or again) active: request refused.
                        if (cactive_s[gi] || lpi.force_on_i[gi]) begin
                            state_next = ST_WAKE;
                            deny_l     = 1'b1;
                        end else begin
                            state_next = ST_STOPPED;
                        end
                    end
                end
                default: state_next = state_t'(2'bxx);
            endcase
        end

        always_comb begin
            idle_cnt_next = '0;
            if (state_reg == ST_RUN && state_next == ST_RUN && idle) begin
                idle_cnt_next = (&idle_cnt_reg) ? idle_cnt_reg : idle_cnt_reg + IDLE_CNT_W'(1);
            end
        end

        always_comb begin
            req_l = 1'b0;
            en_l  = 1'b0;
            case (state_next)
                ST_STOPPED: ;
                ST_WAKE, ST_RUN: begin
                    req_l = 1'b1;
                    en_l  = 1'b1;
                end
                ST_REQ: en_l = 1'b1;
                default: begin
                    req_l = 1'bx;
                    en_l  = 1'bx;
                end
            endcase
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                state_reg    <= ST_STOPPED;
                idle_cnt_reg <= '0;
            end else begin
                state_reg    <= state_next;
                idle_cnt_reg <= idle_cnt_next;
            end
        end

        assign csysreq_next[gi] = req_l;
        assign ch_en_next[gi]   = en_l;
        assign deny_next[gi]    = deny_l;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            csysreq_reg <= '0;
            ch_en_reg   <= '0;
            deny_reg    <= '0;
            hcg_en_reg  <= 1'b0;
        end else begin
            csysreq_reg <= csysreq_next;
            ch_en_reg   <= ch_en_next;
            deny_reg    <= deny_next;
            hcg_en_reg  <= |ch_en_next;
        end
    end

    assign lpi.csysreq_o   = csysreq_reg;
    assign lpi.ch_clk_en_o = ch_en_reg;
    assign lpi.deny_o      = deny_reg;
    assign hcg_clk_en_o    = hcg_en_reg;
endmodule

// File: tb/tb_hcg_lpi_multi_ctrl.sv
// Bench for hcg_lpi_multi_ctrl: hand-derived vector table, directed corner sequences,
// and randomized traffic compared against a cycle-level behavioural model.
module tb_hcg_lpi_multi_ctrl;
    localparam int NCH = 2;
    localparam int SD  = 2;
    localparam int ICW = 8;

    logic           clk_i = 1'b0;
    logic           rstn_i;
    logic [ICW-1:0] idle_thresh_i;
    logic           hcg_clk_en_o;

    hcg_lpi_multi_ctrl_if #(.NUM_CH(NCH)) lpi ();

    hcg_lpi_multi_ctrl #(.NUM_CH(NCH), .SYNC_DEPTH(SD), .IDLE_CNT_W(ICW)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .idle_thresh_i (idle_thresh_i),
        .hcg_clk_en_o  (hcg_clk_en_o),
        .lpi           (lpi)
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: 0 stopped, 1 waking (req raised), 2 running, 3 low-power requested.
    int             m_phase [NCH];
    int             m_idle_run [NCH];
    logic [NCH-1:0] hist_c[$];
    logic [NCH-1:0] hist_a[$];
    logic [NCH-1:0] hist_r[$];
    logic [NCH-1:0] m_req, m_en, m_deny;
    logic           m_hcg;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_phase[c]    = 0;
            m_idle_run[c] = 0;
        end
        hist_c.delete(); hist_a.delete(); hist_r.delete();
        m_req = '0; m_en = '0; m_deny = '0; m_hcg = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [NCH-1:0] cs, as, rs;
        int thr;
        // The FSM sees each async input as it was sampled SD edges earlier.
        cs  = (hist_c.size() >= SD) ? hist_c[SD-1] : '0;
        as  = (hist_a.size() >= SD) ? hist_a[SD-1] : '0;
        rs  = (hist_r.size() >= SD) ? hist_r[SD-1] : '0;
        thr = (idle_thresh_i == 0) ? 1 : int'(idle_thresh_i);
        m_deny = '0;
        for (int c = 0; c < NCH; c++) begin
            bit f, wake, idle;
            f    = lpi.force_on_i[c];
            wake = (cs[c] && rs[c]) || f;
            idle = !cs[c] && !rs[c] && !f;
            case (m_phase[c])
                0: if (wake) m_phase[c] = 1;
                1: if (as[c]) m_phase[c] = 2;
                2: begin
                    if (!idle) m_idle_run[c] = 0;
                    else if (m_idle_run[c] + 1 >= thr) m_phase[c] = 3;
                    else m_idle_run[c]++;
                end
                default: begin
                    if (!as[c]) begin
                        if (cs[c] || f) begin
                            m_phase[c] = 1;
                            m_deny[c]  = 1'b1;
                        end else begin
                            m_phase[c] = 0;
                        end
                    end
                end
            endcase
            if (m_phase[c] != 2) m_idle_run[c] = 0;
            m_req[c] = (m_phase[c] == 1) || (m_phase[c] == 2);
            m_en[c]  = (m_phase[c] != 0);
        end
        m_hcg = |m_en;
        hist_c.push_front(lpi.cactive_i);
        hist_a.push_front(lpi.csysack_i);
        hist_r.push_front(lpi.domain_ready_i);
        if (hist_c.size() > SD) begin
            void'(hist_c.pop_back()); void'(hist_a.pop_back()); void'(hist_r.pop_back());
        end
    endfunction

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
        chk("csysreq", 8'(lpi.csysreq_o), 8'(m_req));
        chk("ch_clk_en", 8'(lpi.ch_clk_en_o), 8'(m_en));
        chk("hcg_clk_en", 8'(hcg_clk_en_o), 8'(m_hcg));
        chk("deny", 8'(lpi.deny_o), 8'(m_deny));
    endtask

    task automatic drive(input logic [NCH-1:0] c, input logic [NCH-1:0] a,
                         input logic [NCH-1:0] r, input logic [NCH-1:0] f);
        lpi.cactive_i      = c;
        lpi.csysack_i      = a;
        lpi.domain_ready_i = r;
        lpi.force_on_i     = f;
    endtask

    // ---------------- vector table (channel 0, thresh 4) ----------------
    typedef struct {
        logic           c, a, r;
        logic           req, en, hcg;
    } vec_t;
    vec_t tbl [21];

    function automatic vec_t v(logic c, logic a, logic r, logic q, logic e, logic h);
        vec_t t;
        t.c = c; t.a = a; t.r = r; t.req = q; t.en = e; t.hcg = h;
        return t;
    endfunction

    initial begin
        int k;
        logic [NCH-1:0] seen;
        bit got;

        // Wake: visible on 3rd edge; then ACK -> RUN.
        tbl[0]  = v(1, 0, 1, 0, 0, 0);
        tbl[1]  = v(1, 0, 1, 0, 0, 0);
        tbl[2]  = v(1, 0, 1, 1, 1, 1);
        for (int i = 3; i <= 5; i++)   tbl[i] = v(1, 1, 1, 1, 1, 1);
        // Three idle cycles then active again: no request.
        for (int i = 6; i <= 8; i++)   tbl[i] = v(0, 1, 0, 1, 1, 1);
        for (int i = 9; i <= 11; i++)  tbl[i] = v(1, 1, 1, 1, 1, 1);
        // Four idle cycles: request (csysreq low, clock still enabled).
        for (int i = 12; i <= 16; i++) tbl[i] = v(0, 1, 0, 1, 1, 1);
        tbl[17] = v(0, 1, 0, 0, 1, 1);
        // ACK drops: accepted, channel stops.
        tbl[18] = v(0, 0, 0, 0, 1, 1);
        tbl[19] = v(0, 0, 0, 0, 1, 1);
        tbl[20] = v(0, 0, 0, 0, 0, 0);

        // ---- reset sanity with random inputs ----
        rstn_i        = 1'b0;
        idle_thresh_i = 8'd4;
        drive(NCH'($urandom), NCH'($urandom), NCH'($urandom), NCH'($urandom));
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_csysreq", 8'(lpi.csysreq_o), 8'h0);
        chk("rst_ch_en", 8'(lpi.ch_clk_en_o), 8'h0);
        chk("rst_hcg", 8'(hcg_clk_en_o), 8'h0);
        chk("rst_deny", 8'(lpi.deny_o), 8'h0);
        drive('0, '0, '0, '0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // ---- table-driven ----
        for (int i = 0; i < 21; i++) begin
            drive({1'b0, tbl[i].c}, {1'b0, tbl[i].a}, {1'b0, tbl[i].r}, '0);
            tick();
            chk($sformatf("tbl%0d_req0", i), 8'(lpi.csysreq_o[0]), 8'(tbl[i].req));
            chk($sformatf("tbl%0d_en0", i), 8'(lpi.ch_clk_en_o[0]), 8'(tbl[i].en));
            chk($sformatf("tbl%0d_hcg", i), 8'(hcg_clk_en_o), 8'(tbl[i].hcg));
            chk($sformatf("tbl%0d_ch1", i), 8'({lpi.csysreq_o[1], lpi.ch_clk_en_o[1]}), 8'h0);
        end

        // ---- reset asserted while ch1 is in RUN ----
        drive(2'b10, 2'b00, 2'b10, '0);
        repeat (3) tick();
        drive(2'b10, 2'b10, 2'b10, '0);
        repeat (3) tick();
        chk("ch1_run_req", 8'(lpi.csysreq_o[1]), 8'h1);
        #3;
        rstn_i = 1'b0;
        #1;
        chk("async_rst_req", 8'(lpi.csysreq_o), 8'h0);
        chk("async_rst_en", 8'(lpi.ch_clk_en_o), 8'h0);
        chk("async_rst_hcg", 8'(hcg_clk_en_o), 8'h0);
        model_reset();
        drive('0, '0, '0, '0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // ---- denial on channel 0 ----
        idle_thresh_i = 8'd2;
        drive(2'b01, 2'b00, 2'b01, '0);
        repeat (3) tick();
        drive(2'b01, 2'b01, 2'b01, '0);
        repeat (3) tick();
        drive(2'b00, 2'b01, 2'b00, '0);
        repeat (6) tick();
        chk("deny_setup_req0", 8'(lpi.csysreq_o[0]), 8'h0);
        chk("deny_setup_en0", 8'(lpi.ch_clk_en_o[0]), 8'h1);
        drive(2'b01, 2'b00, 2'b00, '0);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            chk("deny_en_held", 8'(lpi.ch_clk_en_o[0]), 8'h1);
            if (lpi.deny_o[0]) begin
                got = 1'b1;
                chk("deny_req0", 8'(lpi.csysreq_o[0]), 8'h1);
            end
        end
        chk("deny_seen", 8'(got), 8'h1);
        tick();
        chk("deny_one_cycle", 8'(lpi.deny_o[0]), 8'h0);
        drive(2'b01, 2'b01, 2'b00, '0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("deny_rewake_en", 8'(lpi.ch_clk_en_o[0]), 8'h1);
        end
        drive(2'b00, 2'b01, 2'b00, '0);
        repeat (6) tick();
        drive('0, '0, '0, '0);
        repeat (4) tick();

        // ---- force-on on channel 1 ----
        idle_thresh_i = 8'd4;
        drive('0, '0, '0, 2'b10);
        tick();
        chk("force_req1_1st_edge", 8'(lpi.csysreq_o[1]), 8'h1);
        drive('0, 2'b10, '0, 2'b10);
        repeat (3) tick();
        for (int i = 0; i < 300; i++) tick();
        chk("force_no_req", 8'(lpi.csysreq_o[1]), 8'h1);
        drive('0, 2'b10, '0, '0);
        repeat (6) tick();
        chk("force_released_req", 8'(lpi.csysreq_o[1]), 8'h0);
        drive('0, '0, '0, '0);
        repeat (4) tick();

        // ---- concurrency with thresh 0 ----
        idle_thresh_i = 8'd0;
        drive(2'b11, 2'b00, 2'b11, '0);
        repeat (3) tick();
        drive(2'b11, 2'b11, 2'b11, '0);
        repeat (3) tick();
        drive(2'b00, 2'b11, 2'b00, '0);
        k = 0;
        seen = lpi.csysreq_o;
        while (seen != 2'b00 && k < 8) begin
            tick();
            k++;
            seen = lpi.csysreq_o;
            if (seen == 2'b01 || seen == 2'b10) chk("conc_split", 8'(seen), 8'h3);
        end
        chk("conc_req_cycles", 8'(k), 8'd3);
        drive('0, 2'b10, '0, '0);
        repeat (4) tick();
        chk("conc_ch0_off", 8'(lpi.ch_clk_en_o), 8'h2);
        chk("conc_hcg_on", 8'(hcg_clk_en_o), 8'h1);
        drive('0, '0, '0, '0);
        repeat (4) tick();
        chk("conc_hcg_off", 8'(hcg_clk_en_o), 8'h0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) idle_thresh_i = ICW'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0)
                drive(NCH'($urandom), NCH'($urandom), NCH'($urandom),
                      ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/hcg_lpi_multi_ctrl.md
Name: hcg_lpi_multi_ctrl

Overview:
Multi-channel successor to the single-channel HCG controller. It runs NUM_CH independent AXI low-power-interface (CSYSREQ/CSYSACK/CACTIVE) handshakes, one per peripheral, each with a programmable idle hysteresis counter. It also adds denial handling and a synchronous force-on override. It produces per-channel clock enables plus a combined enable for the shared hierarchical clock gate, and sits between the clock-gate cells and the peripherals' LPI ports.

Parameters:
NUM_CH, 4, number of independent LPI channels (>=1)
SYNC_DEPTH, 2, synchroniser depth for async inputs; 2 or 3 only, any other value behaves as 2
IDLE_CNT_W, 8, width of the per-channel idle counter and of idle_thresh_i (>=1)

Ports:
clk_i  input  1  FSM clock; the only clock
rstn_i  input  1  asynchronous active-low reset
cactive_i  input  NUM_CH  per-channel CACTIVE from peripheral; async, synchronised internally
csysack_i  input  NUM_CH  per-channel CSYSACK from peripheral; async, synchronised internally
domain_ready_i  input  NUM_CH  per-channel subsystem ready; async, synchronised internally
force_on_i  input  NUM_CH  per-channel force-on; synchronous to clk_i, not synchronised
idle_thresh_i  input  IDLE_CNT_W  consecutive idle cycles before a low-power request; quasi-static
csysreq_o  output  NUM_CH  per-channel CSYSREQ to peripheral
ch_clk_en_o  output  NUM_CH  per-channel clock enable
hcg_clk_en_o  output  1  OR of all channel enables, for the shared gate
deny_o  output  NUM_CH  one-cycle pulse when a channel's low-power request is denied

Behaviour:
- Clock and reset: one clock, clk_i. Reset rstn_i is asynchronous and active-low.
- Reset state: all sync flops 0, all channels STOPPED, idle counters 0, and every output 0.
- Reset mid-operation: reset asserted at any point returns all of the above to reset values immediately, without waiting for a clock edge.
- Synchronisation: each bit of cactive_i, csysack_i and domain_ready_i passes through a SYNC_DEPTH-flop synchroniser with reset value 0, giving cactive_s, csysack_s and ready_s.
- Derived terms, per channel:
  - wake = (cactive_s & ready_s) | force_on_i
  - idle = ~cactive_s & ~ready_s & ~force_on_i
  - eff_thresh = max(idle_thresh_i, 1)
- Per-channel FSM states: STOPPED, WAKE, RUN, REQ. Transitions:
  - STOPPED: go to WAKE if wake, else stay.
  - WAKE: go to RUN if csysack_s, else stay.
  - RUN: go to REQ if idle and idle_cnt >= eff_thresh-1, else stay.
  - REQ, csysack_s=0 and cactive_s=0 and force_on_i=0: accepted; go to STOPPED.
  - REQ, csysack_s=0 and (cactive_s or force_on_i): denied; go to WAKE and pulse deny_o for one cycle.
  - REQ, csysack_s=1: stay.
- Output decode, per channel:
  - STOPPED: csysreq=0, ch_clk_en=0.
  - WAKE: csysreq=1, ch_clk_en=1.
  - RUN: csysreq=1, ch_clk_en=1.
  - REQ: csysreq=0, ch_clk_en=1.
- Output timing: all outputs are registered and decoded from the next state, so they change on the same edge as the state. hcg_clk_en_o is registered as the OR of the next-state enables, so it is aligned with ch_clk_en_o.
- Idle counter:
  - Increments each RUN cycle with idle=1 and saturates at all-ones.
  - Clears on any RUN cycle with idle=0 and on leaving RUN.
  - Example: thresh=4 with 4 consecutive idle cycles gives csysreq_o=0 at the end of the 4th.
  - A change to idle_thresh_i mid-count takes effect on the next compare; there is no error.
- Latency: an async input edge is reflected at the outputs on the (SYNC_DEPTH+1)th rising edge after it is first sampled. force_on_i is reflected on the 1st edge.
- Channel independence: channels are fully independent; simultaneous events on different channels are all processed in the same cycle.
- Clock gating: ch_clk_en_o is never 0 while csysreq_o=1. hcg_clk_en_o=0 only when every channel is STOPPED.
- Unreachable state encodings: decode next=X, outputs X (simulation debug aid).

Test Plan:
1. Reset sanity: rstn_i=0 with random inputs -> all outputs 0 and every channel STOPPED. Assert rstn_i=0 while ch1 is in RUN -> csysreq_o, ch_clk_en_o and hcg_clk_en_o go to 0 immediately.
2. Wake, NUM_CH=2, SYNC_DEPTH=2: raise cactive_i[0] and domain_ready_i[0] -> csysreq_o[0]=1, ch_clk_en_o[0]=1 and hcg_clk_en_o=1 on the 3rd edge. Raise csysack_i[0] -> RUN. Channel 1 stays 0 throughout.
3. Idle hysteresis, thresh=4: drop cactive and ready for 3 cycles then re-raise -> no request. Drop for 4 or more cycles -> csysreq_o[0]=0 and ch_clk_en_o=1. Drop csysack -> ch_clk_en_o[0]=0 and hcg_clk_en_o=0.
4. Denial: in REQ, drop csysack_i[0] with cactive_i[0]=1 -> deny_o[0] pulses 1 cycle, csysreq_o[0]=1. Raise csysack_i[0] -> RUN with ch_clk_en_o[0] held at 1 throughout.
5. Force-on: channel STOPPED, force_on_i[1]=1 -> csysreq_o[1]=1 next edge. In RUN with force held, 300 idle cycles -> no request.
6. Concurrency and edge values: both channels requested in the same cycle with idle_thresh_i=0 (behaves as 1) -> both csysreq_o fall after 1 idle cycle. hcg_clk_en_o drops only after the last channel's csysack falls.
